// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path: FSM state type, default widths,
// and the result/byte-count derivations used by the serializer.
package alu_pkg;

  typedef enum logic [0:0] {IDLE, SEND} state_t;

  localparam int DEF_A_WIDTH    = 16;
  localparam int DEF_B_WIDTH    = 16;
  localparam int DEF_BYTE_WIDTH = 8;

  function automatic int res_width(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

  function automatic int num_bytes(input int res_w, input int byte_w);
    return res_w / byte_w;
  endfunction

endpackage

// File: rtl/alu_result_serializer.sv
// Turns each ALU result word into an LSB-first byte frame on a valid/ready link,
// with a one-result holding buffer and a sticky overrun flag for dropped results.
module alu_result_serializer
  import alu_pkg::*;
#(
  parameter int A_WIDTH    = DEF_A_WIDTH,
  parameter int B_WIDTH    = DEF_B_WIDTH,
  parameter int BYTE_WIDTH = DEF_BYTE_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [A_WIDTH+B_WIDTH-1:0]    ALU_OUT,
  input  logic                          OUT_VALID,
  output logic [BYTE_WIDTH-1:0]         TX_DATA,
  output logic                          TX_VALID,
  input  logic                          TX_READY,
  output logic                          TX_LAST,
  output logic                          Busy,
  output logic                          Overrun_Flag,
  input  logic                          Overrun_Clr
);

  localparam int RES_WIDTH = res_width(A_WIDTH, B_WIDTH);
  localparam int NUM_BYTES = num_bytes(RES_WIDTH, BYTE_WIDTH);
  localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  state_t                 r_state;
  logic [IDX_W-1:0]       r_idx;
  logic [RES_WIDTH-1:0]   r_shift;
  logic [RES_WIDTH-1:0]   r_hold;
  logic                   r_hold_vld;
  logic                   r_ovr;

  logic w_send;
  logic w_hs;
  logic w_last;
  logic w_last_hs;
  logic w_drop;

  assign w_send    = (r_state == SEND);
  assign w_hs      = w_send & TX_READY;
  assign w_last    = (r_idx == IDX_W'(NUM_BYTES - 1));
  assign w_last_hs = w_hs & w_last;
  // A result arriving on the final handshake is absorbed by the frame rollover,
  // so only a full hold outside that cycle loses data.
  assign w_drop    = w_send & OUT_VALID & ~w_last_hs & r_hold_vld;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_hold_vld <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_ovr <= w_drop | (r_ovr & ~Overrun_Clr);
      case (r_state)
        IDLE: begin
          if (OUT_VALID) begin
            r_state <= SEND;
            r_idx   <= '0;
          end
        end
        SEND: begin
          if (w_last_hs) begin
            r_idx <= '0;
            if (r_hold_vld) begin
              if (!OUT_VALID) r_hold_vld <= 1'b0;
            end else if (!OUT_VALID) begin
              r_state <= IDLE;
            end
          end else begin
            if (w_hs) r_idx <= r_idx + 1'b1;
            if (OUT_VALID && !r_hold_vld) r_hold_vld <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Data registers carry no reset; their contents only matter while the FSM says so.
  always_ff @(posedge clk) begin
    if (r_state == IDLE) begin
      if (OUT_VALID) r_shift <= ALU_OUT;
    end else if (w_last_hs) begin
      r_shift <= r_hold_vld ? r_hold : ALU_OUT;
      if (r_hold_vld && OUT_VALID) r_hold <= ALU_OUT;
    end else begin
      if (w_hs) r_shift <= r_shift >> BYTE_WIDTH;
      if (OUT_VALID && !r_hold_vld) r_hold <= ALU_OUT;
    end
  end

  assign TX_VALID     = w_send;
  assign TX_DATA      = w_send ? r_shift[BYTE_WIDTH-1:0] : '0;
  assign TX_LAST      = w_send & w_last;
  assign Busy         = w_send | r_hold_vld;
  assign Overrun_Flag = r_ovr;

endmodule

// File: tb/tb_alu_result_serializer.sv
// Scoreboard bench: a frame-level model queues expected bytes as results are
// accepted; a negedge monitor pops and compares on every byte handshake.
module tb_alu_result_serializer;

  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ALU_OUT = '0;
  logic        OUT_VALID = 1'b0;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY = 1'b0;
  logic        TX_LAST;
  logic        Busy;
  logic        Overrun_Flag;
  logic        Overrun_Clr = 1'b0;

  alu_result_serializer dut (
    .clk          (clk),
    .rst          (rst),
    .ALU_OUT      (ALU_OUT),
    .OUT_VALID    (OUT_VALID),
    .TX_DATA      (TX_DATA),
    .TX_VALID     (TX_VALID),
    .TX_READY     (TX_READY),
    .TX_LAST      (TX_LAST),
    .Busy         (Busy),
    .Overrun_Flag (Overrun_Flag),
    .Overrun_Clr  (Overrun_Clr)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  logic [8:0] exp_q[$];
  int         pend = 0;
  bit         exp_ovr = 1'b0;
  bit         started = 1'b0;
  bit         m_drop;
  bit         was_reset = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_last = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pend is the number of bytes still owed to the sink.
  // Capacity is two frames; a frame slot frees on its last accepted byte.
  always @(posedge clk) begin
    was_reset = !rst;
    if (!rst) begin
      exp_q.delete();
      pend    = 0;
      exp_ovr = 1'b0;
    end else begin
      m_drop = 1'b0;
      if (pend > 0 && TX_READY) pend--;
      if (OUT_VALID) begin
        if (pend <= NB) begin
          for (int i = 0; i < NB; i++)
            exp_q.push_back({(i == NB - 1), 8'((ALU_OUT >> (8 * i)) & 32'hFF)});
          pend += NB;
        end else begin
          m_drop = 1'b1;
        end
      end
      if (m_drop) exp_ovr = 1'b1;
      else if (Overrun_Clr) exp_ovr = 1'b0;
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("tx_valid", 32'(TX_VALID), 32'(pend > 0));
      chk("busy", 32'(Busy), 32'(pend > 0));
      chk("overrun", 32'(Overrun_Flag), 32'(exp_ovr));
      if (was_reset) begin
        chk("rst_tx_data", 32'(TX_DATA), 32'h0);
        chk("rst_tx_last", 32'(TX_LAST), 32'h0);
      end else if (prev_stall) begin
        chk("stall_data", 32'(TX_DATA), 32'(prev_data));
        chk("stall_last", 32'(TX_LAST), 32'(prev_last));
      end
      if (TX_VALID && TX_READY) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %h expected none at %0t", TX_DATA, $time);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("tx_data", 32'(TX_DATA), 32'(e[7:0]));
          chk("tx_last", 32'(TX_LAST), 32'(e[8]));
        end
      end
      prev_stall = TX_VALID && !TX_READY;
      prev_data  = TX_DATA;
      prev_last  = TX_LAST;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [31:0] w);
    ALU_OUT   = w;
    OUT_VALID = 1'b1;
    step();
    OUT_VALID = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;

    // single result, ready high
    TX_READY = 1'b1;
    send1(32'hA1B2C3D4);
    repeat (6) step();

    // backpressure at byte 1
    send1(32'hA1B2C3D4);
    step();
    TX_READY = 1'b0;
    repeat (3) step();
    TX_READY = 1'b1;
    repeat (6) step();

    // back-to-back results
    OUT_VALID = 1'b1;
    ALU_OUT   = 32'h00000001;
    step();
    ALU_OUT   = 32'hFFFFFFFF;
    step();
    OUT_VALID = 1'b0;
    repeat (10) step();

    // overrun: three results against a stalled sink
    TX_READY  = 1'b0;
    OUT_VALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ALU_OUT = $urandom;
      step();
    end
    OUT_VALID = 1'b0;
    step();
    TX_READY = 1'b1;
    repeat (12) step();
    Overrun_Clr = 1'b1;
    step();
    Overrun_Clr = 1'b0;
    step();

    // new result coincident with final-byte handshake
    send1(32'h11223344);
    repeat (3) step();
    send1(32'h55667788);
    repeat (6) step();

    // reset mid-frame, then a fresh frame
    send1(32'hCAFEBABE);
    repeat (2) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    repeat (3) step();
    send1(32'h0BADF00D);
    repeat (6) step();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      ALU_OUT     = $urandom;
      OUT_VALID   = ($urandom % 3) == 0;
      TX_READY    = ($urandom % 4) != 0;
      Overrun_Clr = ($urandom % 16) == 0;
      rst         = ($urandom % 200) != 0;
      step();
    end

    // drain
    rst         = 1'b1;
    OUT_VALID   = 1'b0;
    Overrun_Clr = 1'b0;
    TX_READY    = 1'b1;
    for (int n = 0; n < 50 && pend != 0; n++) step();
    chk("drain_pending", 32'(pend), 32'h0);
    step();
    chk("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
